// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the uart_controller peripheral
package uart_pkg;

   // Register map
   localparam logic [7:0] UART_ADDR_STATUS = 8'h00;
   localparam logic [7:0] UART_ADDR_BRG_LO = 8'h01;
   localparam logic [7:0] UART_ADDR_BRG_HI = 8'h02;
   localparam logic [7:0] UART_ADDR_TXDATA = 8'h03;
   localparam logic [7:0] UART_ADDR_RXDATA = 8'h04;

   // STATUS register bit positions
   localparam int STAT_TXBUSY  = 0;
   localparam int STAT_RXFULL  = 1;
   localparam int STAT_OVERRUN = 2;

   // Baud strobes per serial bit
   localparam int OVERSAMPLE = 16;

   // Frame state shared by the transmitter and the receiver
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serialiser paced by the 16x baud strobe
module uart_tx
   import uart_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       brg_stb_i,
   input  logic       we_i,
   input  logic [7:0] din_i,
   output logic       dout_o,
   output logic       busy_o
);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_START = ST_START;
   localparam logic [1:0] S_DATA  = ST_DATA;
   localparam logic [1:0] S_STOP  = ST_STOP;
   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

   logic [1:0] state;
   logic       armed;      // byte accepted, start bit waits for the next strobe
   logic [3:0] tick;
   logic [2:0] bit_idx;
   logic [7:0] shreg;

   // Frame sequencer: every bit lasts OVERSAMPLE strobes, data shifted out LSB first
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         armed   <= 1'b0;
         tick    <= 4'd0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (we_i) begin
                  state   <= S_START;
                  armed   <= 1'b1;
                  shreg   <= din_i;
                  tick    <= 4'd0;
                  bit_idx <= 3'd0;
               end
            end
            S_START: begin
               if (brg_stb_i) begin
                  if (armed) begin
                     armed <= 1'b0;
                     tick  <= 4'd0;
                  end else if (tick == TICK_LAST) begin
                     tick  <= 4'd0;
                     state <= S_DATA;
                  end else begin
                     tick <= tick + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (brg_stb_i) begin
                  if (tick == TICK_LAST) begin
                     tick  <= 4'd0;
                     shreg <= {1'b0, shreg[7:1]};
                     if (bit_idx == 3'd7) begin
                        state <= S_STOP;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                     end
                  end else begin
                     tick <= tick + 4'd1;
                  end
               end
            end
            S_STOP: begin
               if (brg_stb_i) begin
                  if (tick == TICK_LAST) begin
                     tick  <= 4'd0;
                     state <= S_IDLE;
                  end else begin
                     tick <= tick + 4'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Line level: high while idle, armed or in stop, low for the start bit
   always_comb begin
      dout_o = 1'b1;
      case (state)
         S_START: dout_o = armed;
         S_DATA:  dout_o = shreg[0];
         default: dout_o = 1'b1;
      endcase
   end

   assign busy_o = (state != S_IDLE);

endmodule

// File: rtl/uart_controller.sv
// rtl/uart_controller.sv - byte-wide 8N1 UART register block; UART_OVERRUN_EN adds the OVERRUN status bit
module uart_controller
   import uart_pkg::*;
#(
   parameter logic [15:0] BRG_RESET = 16'h0000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       we_i,
   input  logic [7:0] addr_i,
   input  logic [7:0] din_i,
   output logic [7:0] dout_o,
   output logic       tx_o,
   input  logic       rx_i
);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_START = ST_START;
   localparam logic [1:0] S_DATA  = ST_DATA;
   localparam logic [1:0] S_STOP  = ST_STOP;
   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);

   logic        wr_en, rd_en, tx_we, rd_rxdata;
   logic [7:0]  brg_lo, brg_hi;
   logic [15:0] brg_cnt;
   logic        brg_stb;
   logic        tx_busy;
   logic        rx_s1, rx_s2, rx_prev;
   logic [1:0]  rx_state;
   logic [3:0]  rx_tick;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shreg;
   logic        rx_done;
   logic [7:0]  rxdata;
   logic        rxfull;
   logic        overrun_bit;
   logic [7:0]  rd_data;

   assign wr_en     = en_i & we_i;
   assign rd_en     = en_i & ~we_i;
   assign tx_we     = wr_en & (addr_i == UART_ADDR_TXDATA);
   assign rd_rxdata = rd_en & (addr_i == UART_ADDR_RXDATA);

   // Baud generator: down-counter, strobe on zero, reload picks up the latest divisor
   assign brg_stb = (brg_cnt == 16'd0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         brg_cnt <= BRG_RESET;
      end else if (brg_stb) begin
         brg_cnt <= {brg_hi, brg_lo};
      end else begin
         brg_cnt <= brg_cnt - 16'd1;
      end
   end

   uart_tx u_tx (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .brg_stb_i (brg_stb),
      .we_i      (tx_we),
      .din_i     (din_i),
      .dout_o    (tx_o),
      .busy_o    (tx_busy)
   );

   // Two-flop synchroniser plus a delayed copy for falling-edge detection
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx_i;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // Receiver: confirm start at mid-bit, then sample every OVERSAMPLE strobes near bit centre
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_state <= S_IDLE;
         rx_tick  <= 4'd0;
         rx_bit   <= 3'd0;
         rx_shreg <= 8'h00;
         rx_done  <= 1'b0;
      end else begin
         rx_done <= 1'b0;
         case (rx_state)
            S_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_state <= S_START;
                  rx_tick  <= 4'd0;
               end
            end
            S_START: begin
               if (brg_stb) begin
                  if (rx_tick == TICK_HALF) begin
                     rx_tick <= 4'd0;
                     rx_bit  <= 3'd0;
                     rx_state <= rx_s2 ? S_IDLE : S_DATA;
                  end else begin
                     rx_tick <= rx_tick + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (brg_stb) begin
                  if (rx_tick == TICK_LAST) begin
                     rx_tick  <= 4'd0;
                     rx_shreg <= {rx_s2, rx_shreg[7:1]};
                     if (rx_bit == 3'd7) begin
                        rx_state <= S_STOP;
                     end else begin
                        rx_bit <= rx_bit + 3'd1;
                     end
                  end else begin
                     rx_tick <= rx_tick + 4'd1;
                  end
               end
            end
            S_STOP: begin
               if (brg_stb) begin
                  if (rx_tick == TICK_LAST) begin
                     rx_tick  <= 4'd0;
                     rx_state <= S_IDLE;
                     rx_done  <= rx_s2;   // low stop bit is a framing error: drop the byte
                  end else begin
                     rx_tick <= rx_tick + 4'd1;
                  end
               end
            end
            default: rx_state <= S_IDLE;
         endcase
      end
   end

   // Register file: divisor writes, registered reads, receive buffer (new byte beats a same-cycle read)
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         brg_lo <= BRG_RESET[7:0];
         brg_hi <= BRG_RESET[15:8];
         dout_o <= 8'h00;
         rxdata <= 8'h00;
         rxfull <= 1'b0;
      end else begin
         if (wr_en && addr_i == UART_ADDR_BRG_LO) brg_lo <= din_i;
         if (wr_en && addr_i == UART_ADDR_BRG_HI) brg_hi <= din_i;
         if (rd_en) dout_o <= rd_data;
         if (rx_done) begin
            rxdata <= rx_shreg;
            rxfull <= 1'b1;
         end else if (rd_rxdata) begin
            rxfull <= 1'b0;
         end
      end
   end

`ifdef UART_OVERRUN_EN
   logic overrun;

   // Overrun flag: a byte landed on top of an unread one; cleared by reading RXDATA
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         overrun <= 1'b0;
      end else if (rd_rxdata) begin
         overrun <= 1'b0;
      end else if (rx_done && rxfull) begin
         overrun <= 1'b1;
      end
   end

   assign overrun_bit = overrun;
`else
   assign overrun_bit = 1'b0;
`endif

   // Read mux; write-only and unmapped addresses read as zero
   always_comb begin
      rd_data = 8'h00;
      case (addr_i)
         UART_ADDR_STATUS: begin
            rd_data[STAT_TXBUSY]  = tx_busy;
            rd_data[STAT_RXFULL]  = rxfull;
            rd_data[STAT_OVERRUN] = overrun_bit;
         end
         UART_ADDR_BRG_LO: rd_data = brg_lo;
         UART_ADDR_BRG_HI: rd_data = brg_hi;
         UART_ADDR_RXDATA: rd_data = rxdata;
         default:          rd_data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_uart_controller.sv
// tb/tb_uart_controller.sv - randomized self-checking bench for uart_controller against a frame-level model
module tb_uart_controller;

   localparam logic [15:0] BRG_RST = 16'h0000;

   logic       clk = 1'b0;
   logic       rst_i, en_i, we_i, tx_o, rx_i;
   logic [7:0] addr_i, din_i, dout_o;

   always #5 clk = ~clk;

   uart_controller #(.BRG_RESET(BRG_RST)) dut (
      .clk_i  (clk),
      .rst_i  (rst_i),
      .en_i   (en_i),
      .we_i   (we_i),
      .addr_i (addr_i),
      .din_i  (din_i),
      .dout_o (dout_o),
      .tx_o   (tx_o),
      .rx_i   (rx_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: strobe schedule, frame progress counted in strobes, register contents
   int         cyc = 0;
   int         next_stb = 0;
   bit         m_valid = 1'b0;
   logic [15:0] m_brg = 16'h0;
   bit         m_act = 1'b0;
   int         m_n = 0;
   logic [7:0] m_txb = 8'h0;
   logic [7:0] m_dout = 8'h0;
   logic [7:0] m_rxdata = 8'h0;
   bit         m_rxfull = 1'b0;
   bit         m_ovr = 1'b0;
   bit         rx_req = 1'b0;
   logic [7:0] rx_req_byte = 8'h0;

   initial forever begin
      @(negedge clk);
      if (m_valid) begin : cmp
         logic etx;
         int   b;
         etx = 1'b1;
         if (m_act && m_n >= 1) begin
            b = (m_n - 1) / 16;
            if (b == 0) etx = 1'b0;
            else if (b <= 8) etx = m_txb[b-1];
         end
         check("cycle{tx,stb,dout}", {22'd0, tx_o, dut.brg_stb, dout_o},
               {22'd0, etx, (cyc == next_stb), m_dout});
      end
      if (rst_i) begin
         m_brg = BRG_RST; next_stb = cyc + 1 + int'(BRG_RST);
         m_act = 1'b0; m_n = 0; m_dout = 8'h00; m_rxdata = 8'h00;
         m_rxfull = 1'b0; m_ovr = 1'b0; rx_req = 1'b0; m_valid = 1'b1;
      end else if (m_valid) begin : step
         bit stb;
         stb = (cyc == next_stb);
         if (rx_req) begin
`ifdef UART_OVERRUN_EN
            if (m_rxfull) m_ovr = 1'b1;
`endif
            m_rxdata = rx_req_byte; m_rxfull = 1'b1; rx_req = 1'b0;
         end
         if (en_i && !we_i) begin
            case (addr_i)
               8'h00: m_dout = {5'b0, m_ovr, m_rxfull, m_act};
               8'h01: m_dout = m_brg[7:0];
               8'h02: m_dout = m_brg[15:8];
               8'h04: begin m_dout = m_rxdata; m_rxfull = 1'b0; m_ovr = 1'b0; end
               default: m_dout = 8'h00;
            endcase
         end
         if (stb) next_stb = cyc + int'(m_brg) + 1;
         if (en_i && we_i && addr_i == 8'h01) m_brg[7:0]  = din_i;
         if (en_i && we_i && addr_i == 8'h02) m_brg[15:8] = din_i;
         if (m_act) begin
            if (stb) begin
               m_n++;
               if (m_n == 161) m_act = 1'b0;
            end
         end else if (en_i && we_i && addr_i == 8'h03) begin
            m_act = 1'b1; m_n = 0; m_txb = din_i;
         end
      end
      cyc++;
   end

   // Stimulus helpers: all inputs change 1 time unit after a rising edge
   task automatic tick_n(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic acc(input logic w, input logic [7:0] a, input logic [7:0] d);
      en_i = 1'b1; we_i = w; addr_i = a; din_i = d;
      tick_n(1);
      en_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic set_brg(input int b);
      logic [15:0] v;
      v = 16'(b);
      acc(1'b1, 8'h01, v[7:0]);
      acc(1'b1, 8'h02, v[15:8]);
      tick_n(8);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stopb, input int brg);
      logic [9:0] fr;
      fr = {stopb, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_i = fr[i];
         tick_n(16 * (brg + 1));
      end
      rx_i = 1'b1;
      tick_n(4);
      if (stopb) begin rx_req_byte = b; rx_req = 1'b1; end
      tick_n(1);
   endtask

   task automatic glitch(input int brg);
      rx_i = 1'b0;
      tick_n(4 * (brg + 1));
      rx_i = 1'b1;
      tick_n(24 * (brg + 1) + 4);
   endtask

   logic [7:0] addrs [7] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF};
   logic       txs [340];
   logic [9:0] exp_frame;

   initial begin
      int busy_cnt, f, stb_cnt;
      rst_i = 1'b1; en_i = 1'b0; we_i = 1'b0; addr_i = 8'h00; din_i = 8'h00; rx_i = 1'b1;
      tick_n(3);
      rst_i = 1'b0;
      check("reset_tx", tx_o, 1);
      acc(1'b0, 8'h00, 8'h00);
      check("reset_status", dout_o, 8'h00);

      set_brg(1);
      acc(1'b0, 8'h01, 8'h00); check("brg_lo_readback", dout_o, 8'h01);
      acc(1'b0, 8'h02, 8'h00); check("brg_hi_readback", dout_o, 8'h00);
      stb_cnt = 0;
      for (int i = 0; i < 8; i++) begin stb_cnt += int'(dut.brg_stb); tick_n(1); end
      check("stb_every_2", stb_cnt, 4);

      // Transmit 0x75 while polling STATUS every cycle
      acc(1'b1, 8'h03, 8'h75);
      busy_cnt = 0;
      for (int i = 0; i < 340; i++) begin
         en_i = 1'b1; we_i = 1'b0; addr_i = 8'h00;
         tick_n(1);
         txs[i] = tx_o;
         busy_cnt += int'(dout_o[0]);
      end
      en_i = 1'b0;
      f = -1;
      for (int i = 0; i < 4; i++) if (f < 0 && txs[i] == 1'b0) f = i;
      check("tx_start_pos", (f == 0 || f == 1), 1);
      if (f < 0) f = 0;
      exp_frame = 10'b1011101010;
      for (int k = 0; k < 10; k++)
         check($sformatf("tx_bit%0d", k), txs[f + 16 + 32 * k], exp_frame[k]);
      check("tx_busy_len", (busy_cnt == 321 || busy_cnt == 322), 1);

      // Receive 0x75
      send_rx(8'h75, 1'b1, 1);
      acc(1'b0, 8'h00, 8'h00); check("rx_status_full", dout_o, 8'h02);
      acc(1'b0, 8'h04, 8'h00); check("rx_data", dout_o, 8'h75);
      acc(1'b0, 8'h00, 8'h00); check("rx_status_clear", dout_o, 8'h00);

      glitch(1);
      acc(1'b0, 8'h00, 8'h00); check("glitch_status", dout_o, 8'h00);

`ifdef UART_OVERRUN_EN
      send_rx(8'h75, 1'b1, 1);
      send_rx(8'h3C, 1'b1, 1);
      acc(1'b0, 8'h00, 8'h00); check("ovr_status", dout_o, 8'h06);
      acc(1'b0, 8'h04, 8'h00); check("ovr_data", dout_o, 8'h3C);
      acc(1'b0, 8'h00, 8'h00); check("ovr_cleared", dout_o, 8'h00);
`endif

      // Randomized mix of transmit, receive, framing errors and glitches
      for (int it = 0; it < 14; it++) begin
         int kind, b, k, r;
         b = $urandom_range(0, 3);
         set_brg(b);
         kind = $urandom_range(0, 3);
         case (kind)
            0: begin
               acc(1'b1, 8'h03, 8'($urandom_range(0, 255)));
               k = 0;
               while (m_act && k < 8000) begin
                  r = $urandom_range(0, 9);
                  if (r <= 2)      acc(1'b0, addrs[$urandom_range(0, 6)], 8'h00);
                  else if (r == 3) acc(1'b1, 8'h03, 8'($urandom_range(0, 255)));
                  else if (r == 4) acc(1'b1, addrs[($urandom_range(0, 1) == 0) ? 0 : 6], 8'($urandom_range(0, 255)));
                  else if (r == 5 && $urandom_range(0, 15) == 0) acc(1'b1, 8'h01, 8'($urandom_range(0, 3)));
                  else tick_n(1);
                  k++;
               end
               acc(1'b0, 8'h00, 8'h00);
               check("tx_done_busy", dout_o[0], 1'b0);
            end
            1: begin
               send_rx(8'($urandom_range(0, 255)), 1'b1, b);
               if ($urandom_range(0, 1) == 1) acc(1'b0, 8'h04, 8'h00);
               acc(1'b0, 8'h00, 8'h00);
            end
            2: begin
               send_rx(8'($urandom_range(0, 255)), 1'b0, b);
               acc(1'b0, 8'h00, 8'h00);
            end
            default: begin
               glitch(b);
               acc(1'b0, 8'h00, 8'h00);
            end
         endcase
      end

      // Reset in the middle of a transmission
      set_brg(2);
      acc(1'b1, 8'h03, 8'h00);
      tick_n(100);
      rst_i = 1'b1;
      tick_n(1);
      rst_i = 1'b0;
      check("abort_tx_high", tx_o, 1);
      tick_n(2);
      acc(1'b0, 8'h00, 8'h00); check("abort_status", dout_o, 8'h00);
      acc(1'b0, 8'h01, 8'h00); check("abort_brg_lo", dout_o, 8'h00);
      tick_n(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
